// File: rtl/camera_ctrl_if.sv
// Camera connector pins plus the controller's coordinate/status outputs.
// Signal names follow the sensor-side pin names used by the rest of the system.
interface camera_ctrl_if;
  logic       START_I2C;
  logic       VSYNC;
  logic       HREF;
  logic       PCLK;
  logic [8:0] PIXEL_ROW;
  logic [9:0] PIXEL_COLUMN;
  logic       DEBUG;

  modport master (
    output START_I2C, VSYNC, HREF, PCLK,
    input  PIXEL_ROW, PIXEL_COLUMN, DEBUG
  );

  modport slave (
    input  START_I2C, VSYNC, HREF, PCLK,
    output PIXEL_ROW, PIXEL_COLUMN, DEBUG
  );
endinterface

// File: rtl/camera_ctrl.sv
// Parallel-bus camera capture controller: config settling phase, then
// VSYNC/HREF/PCLK tracking on the system clock to produce pixel coordinates.
module camera_ctrl #(
  parameter int CFG_CYCLES = 200,
  parameter int H_PIXELS   = 640,
  parameter int V_LINES    = 480
) (
  input  logic          CLK,
  input  logic          RST,
  camera_ctrl_if.slave  bus
);
  localparam int CW = $clog2(CFG_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, CONFIG, READY} state_t;

  state_t        state;
  logic [CW-1:0] cfg_cnt;
  logic          debug;

  // Bit order in the sync chain: {vsync, href, pclk}
  logic [2:0] sync1, sync2, prev;
  logic       vs, hr, pclk_rise, href_rise, href_fall;

  logic       phase;
  logic [8:0] row;
  logic [9:0] col;

  assign vs        = sync2[2];
  assign hr        = sync2[1];
  assign href_rise = sync2[1] & ~prev[1];
  assign href_fall = ~sync2[1] & prev[1];
  assign pclk_rise = sync2[0] & ~prev[0];

  always_ff @(posedge CLK) begin
    if (RST) begin
      sync1 <= '0;
      sync2 <= '0;
      prev  <= '0;
    end else begin
      sync1 <= {bus.VSYNC, bus.HREF, bus.PCLK};
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= IDLE;
      cfg_cnt <= '0;
      debug   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          cfg_cnt <= '0;
          debug   <= 1'b0;
          if (bus.START_I2C) state <= CONFIG;
        end
        CONFIG: begin
          if (cfg_cnt == CW'(CFG_CYCLES - 1)) begin
            state <= READY;
            debug <= 1'b1;
          end else begin
            cfg_cnt <= cfg_cnt + 1'b1;
          end
        end
        READY:   debug <= 1'b1;
        default: begin
          state <= IDLE;
          debug <= 1'b0;
        end
      endcase
    end
  end

  // VSYNC outranks every line/pixel event; href_fall swallows a same-cycle pixel.
  always_ff @(posedge CLK) begin
    if (RST || state != READY) begin
      row   <= '0;
      col   <= '0;
      phase <= 1'b0;
    end else if (vs) begin
      row   <= '0;
      col   <= '0;
      phase <= 1'b0;
    end else if (href_rise) begin
      col   <= '0;
      phase <= 1'b0;
    end else if (href_fall) begin
      if (row != 9'(V_LINES - 1)) row <= row + 1'b1;
      phase <= 1'b0;
    end else if (pclk_rise && hr) begin
      phase <= ~phase;
      if (phase && col != 10'(H_PIXELS - 1)) col <= col + 1'b1;
    end
  end

  assign bus.PIXEL_ROW    = row;
  assign bus.PIXEL_COLUMN = col;
  assign bus.DEBUG        = debug;
endmodule

// File: tb/tb_camera_ctrl.sv
// Bench for camera_ctrl: table-driven line vectors, directed corner sequences
// and randomized framing traffic against a cycle-level reference model.
module tb_camera_ctrl;
  localparam int CFG = 200;
  localparam int HP  = 640;
  localparam int VL  = 480;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  camera_ctrl_if bus();

  camera_ctrl #(.CFG_CYCLES(CFG), .H_PIXELS(HP), .V_LINES(VL)) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus.slave)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: pin history as a delay line, config progress as an elapsed count
  logic [2:0] hist[$];
  int m_since = -1;
  int m_row = 0, m_col = 0, m_ph = 0;

  typedef struct {
    int npclk;
    int exp_col;
    int exp_row;
  } line_vec_t;
  line_vec_t lines[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic model_edge(input logic vs, input logic hr, input logic pc);
    logic [2:0] cur, prv;
    bit ready;
    ready = (m_since >= CFG);
    if (RST) begin
      m_since = -1;
      m_row = 0; m_col = 0; m_ph = 0;
      hist = '{3'b000, 3'b000, 3'b000, 3'b000};
      return;
    end
    hist.push_back({vs, hr, pc});
    void'(hist.pop_front());
    cur = hist[1];
    prv = hist[0];
    if (m_since >= 0) begin
      if (m_since < CFG) m_since++;
    end else if (bus.START_I2C) begin
      m_since = 0;
    end
    if (!ready || cur[2]) begin
      m_row = 0; m_col = 0; m_ph = 0;
    end else if (cur[1] && !prv[1]) begin
      m_col = 0; m_ph = 0;
    end else if (!cur[1] && prv[1]) begin
      m_row = (m_row + 1 > VL - 1) ? VL - 1 : m_row + 1;
      m_ph = 0;
    end else if (cur[0] && !prv[0] && cur[1]) begin
      if (m_ph == 1) m_col = (m_col + 1 > HP - 1) ? HP - 1 : m_col + 1;
      m_ph = 1 - m_ph;
    end
  endtask

  task automatic step(input logic vs, input logic hr, input logic pc);
    int exp_dbg;
    bus.VSYNC = vs;
    bus.HREF  = hr;
    bus.PCLK  = pc;
    @(posedge CLK);
    model_edge(vs, hr, pc);
    #1;
    exp_dbg = (m_since >= CFG) ? 1 : 0;
    checks++;
    if (bus.PIXEL_ROW !== 9'(m_row) || bus.PIXEL_COLUMN !== 10'(m_col) || bus.DEBUG !== 1'(exp_dbg)) begin
      failures++;
      $display("FAIL track t=%0t actual row=%0d col=%0d dbg=%0d required row=%0d col=%0d dbg=%0d",
               $time, bus.PIXEL_ROW, bus.PIXEL_COLUMN, bus.DEBUG, m_row, m_col, exp_dbg);
    end
  endtask

  task automatic vsync_pulse();
    repeat (3) step(1'b1, 1'b0, 1'b0);
    repeat (4) step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic pclk_periods(input int n);
    repeat (n) begin
      repeat (2) step(1'b0, 1'b1, 1'b1);
      repeat (2) step(1'b0, 1'b1, 1'b0);
    end
  endtask

  // Leaves HREF high and settled so the caller can read the column
  task automatic line_open(input int n);
    repeat (2) step(1'b0, 1'b1, 1'b0);
    pclk_periods(n);
    repeat (3) step(1'b0, 1'b1, 1'b0);
  endtask

  task automatic line_close();
    repeat (4) step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic measure_cfg(input string name);
    int first;
    first = -1;
    for (int i = 0; i < CFG + 30; i++) begin
      step(1'b0, 1'b0, 1'b0);
      if (bus.DEBUG === 1'b1 && first < 0) first = i;
    end
    chk(name, first, CFG);
  endtask

  initial begin
    lines[0] = '{10, 5, 1};
    lines[1] = '{3, 1, 2};
    lines[2] = '{1, 0, 3};
    lines[3] = '{0, 0, 4};
    lines[4] = '{24, 12, 5};
    lines[5] = '{2, 1, 6};
    hist = '{3'b000, 3'b000, 3'b000, 3'b000};

    bus.START_I2C = 1'b1;
    bus.VSYNC = 1'b0; bus.HREF = 1'b0; bus.PCLK = 1'b0;

    // Reset held with START_I2C asserted
    RST = 1'b1;
    repeat (2) step(1'b0, 1'b0, 1'b0);
    chk("rst_debug", bus.DEBUG, 0);
    chk("rst_row", bus.PIXEL_ROW, 0);
    chk("rst_col", bus.PIXEL_COLUMN, 0);

    // Configuration latency
    RST = 1'b0;
    measure_cfg("cfg_latency");
    chk("cfg_debug_held", bus.DEBUG, 1);

    // Table-driven lines
    vsync_pulse();
    for (int i = 0; i < 6; i++) begin
      line_open(lines[i].npclk);
      chk($sformatf("line%0d_col", i), bus.PIXEL_COLUMN, lines[i].exp_col);
      line_close();
      chk($sformatf("line%0d_row", i), bus.PIXEL_ROW, lines[i].exp_row);
    end

    // Frame restart mid-line at row 3, column 12
    vsync_pulse();
    repeat (3) begin line_open(2); line_close(); end
    line_open(24);
    chk("restart_pre_row", bus.PIXEL_ROW, 3);
    chk("restart_pre_col", bus.PIXEL_COLUMN, 12);
    repeat (2) step(1'b1, 1'b1, 1'b0);
    chk("restart_edge2_col", bus.PIXEL_COLUMN, 12);
    step(1'b1, 1'b1, 1'b0);
    chk("restart_edge3_row", bus.PIXEL_ROW, 0);
    chk("restart_edge3_col", bus.PIXEL_COLUMN, 0);
    repeat (2) step(1'b1, 1'b1, 1'b0);
    line_close();

    // Column and row saturation
    vsync_pulse();
    line_open(1300);
    chk("sat_col", bus.PIXEL_COLUMN, HP - 1);
    line_close();
    vsync_pulse();
    repeat (481) begin
      repeat (2) step(1'b0, 1'b1, 1'b0);
      repeat (2) step(1'b0, 1'b0, 1'b0);
    end
    repeat (3) step(1'b0, 1'b0, 1'b0);
    chk("sat_row", bus.PIXEL_ROW, VL - 1);

    // href_fall coinciding with pclk_rise: second byte is discarded
    vsync_pulse();
    repeat (2) step(1'b0, 1'b1, 1'b0);
    repeat (2) step(1'b0, 1'b1, 1'b1);
    repeat (2) step(1'b0, 1'b1, 1'b0);
    repeat (2) step(1'b0, 1'b0, 1'b1);
    repeat (4) step(1'b0, 1'b0, 1'b0);
    chk("coinc_col", bus.PIXEL_COLUMN, 0);
    chk("coinc_row", bus.PIXEL_ROW, 1);

    // Randomized framing traffic
    begin
      logic pc, hr, vs;
      int rem, vs_rem;
      pc = 1'b0; hr = 1'b0; vs = 1'b0; rem = 2; vs_rem = 0;
      vsync_pulse();
      for (int i = 0; i < 3000; i++) begin
        rem--;
        if (rem == 0) begin
          pc  = ~pc;
          rem = $urandom_range(2, 5);
        end
        if (!pc && $urandom_range(0, 7) == 0) hr = ~hr;
        if (vs_rem > 0) vs_rem--;
        else if ($urandom_range(0, 299) == 0) vs_rem = 3;
        vs = (vs_rem > 0);
        step(vs, hr, pc);
      end
      repeat (4) step(1'b0, 1'b0, 1'b0);
    end

    // Pre-config gating and reset mid-CONFIG
    RST = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    RST = 1'b0;
    for (int i = 0; i < 25; i++) begin
      repeat (2) step(1'b0, 1'b1, 1'b1);
      repeat (2) step(1'b0, (i % 5) != 4, 1'b0);
    end
    chk("gate_row", bus.PIXEL_ROW, 0);
    chk("gate_col", bus.PIXEL_COLUMN, 0);
    RST = 1'b1;
    bus.START_I2C = 1'b0;
    step(1'b0, 1'b0, 1'b0);
    chk("midcfg_rst_debug", bus.DEBUG, 0);
    RST = 1'b0;
    repeat (CFG + 10) step(1'b0, 1'b0, 1'b0);
    chk("no_restart_debug", bus.DEBUG, 0);
    bus.START_I2C = 1'b1;
    measure_cfg("cfg_relatency");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
